// File: rtl/snake_body_tracker.sv
// Snake body store: circular buffer of (x,y) cells, one-cell move per step,
// optional growth, then a sequential head-versus-body collision scan.
module snake_body_tracker #(
  parameter int unsigned COORD_W  = 5,
  parameter int unsigned LEN_W    = 5,
  parameter int unsigned MAX_LEN  = 31,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned START_X  = 16,
  parameter int unsigned START_Y  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic [1:0]         dir,
  input  logic               grow,
  input  logic [LEN_W-1:0]   seg_idx,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [LEN_W-1:0]   length,
  output logic               busy,
  output logic               done,
  output logic               collide,
  output logic [COORD_W-1:0] seg_x,
  output logic [COORD_W-1:0] seg_y,
  output logic               seg_valid
);

  localparam int unsigned      DEPTH = 2 ** LEN_W;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, MOVE, SCAN, DONE} state_t;

  state_t             state, state_nx;
  logic [COORD_W-1:0] bx [DEPTH];
  logic [COORD_W-1:0] by [DEPTH];
  logic [LEN_W-1:0]   head_ptr, ptr_nx, idx, len_nx;
  logic [1:0]         heading, heading_nx;
  logic               grow_pend, grow_eff;
  logic [COORD_W-1:0] nx_x, nx_y;

  // Move arithmetic: heading filter (reverse rejected), next head, next length
  always_comb begin
    heading_nx = (dir == (heading ^ 2'b10)) ? heading : dir;
    nx_x       = head_x;
    nx_y       = head_y;
    case (heading_nx)
      2'b00:   nx_y = head_y - COORD_W'(1);
      2'b01:   nx_x = head_x + COORD_W'(1);
      2'b10:   nx_y = head_y + COORD_W'(1);
      default: nx_x = head_x - COORD_W'(1);
    endcase
    ptr_nx   = head_ptr + LEN_W'(1);
    grow_eff = grow_pend | grow;
    len_nx   = (grow_eff && (length < MAX_L)) ? length + LEN_W'(1) : length;
  end

  // Next-state and status outputs
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (step && !collide) state_nx = MOVE;
      MOVE: state_nx = (len_nx == LEN_W'(1)) ? DONE : SCAN;
      SCAN: if (idx == length - LEN_W'(1)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Body buffer, head/length bookkeeping, collision flag and read port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_ptr  <= '0;
      length    <= LEN_W'(INIT_LEN);
      heading   <= 2'b01;
      grow_pend <= 1'b0;
      collide   <= 1'b0;
      idx       <= '0;
      head_x    <= COORD_W'(START_X);
      head_y    <= COORD_W'(START_Y);
      seg_x     <= '0;
      seg_y     <= '0;
      seg_valid <= 1'b0;
      // entry e holds segment (DEPTH - e) mod DEPTH while head_ptr is 0
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (((DEPTH - e) % DEPTH) < INIT_LEN) begin
          bx[e] <= COORD_W'(START_X - ((DEPTH - e) % DEPTH));
          by[e] <= COORD_W'(START_Y);
        end else begin
          bx[e] <= '0;
          by[e] <= '0;
        end
      end
    end else begin
      seg_x     <= bx[head_ptr - seg_idx];
      seg_y     <= by[head_ptr - seg_idx];
      seg_valid <= (seg_idx < length);
      if (grow) grow_pend <= 1'b1;
      case (state)
        MOVE: begin
          heading    <= heading_nx;
          head_x     <= nx_x;
          head_y     <= nx_y;
          head_ptr   <= ptr_nx;
          bx[ptr_nx] <= nx_x;
          by[ptr_nx] <= nx_y;
          length     <= len_nx;
          // a grow arriving in this cycle was folded into len_nx
          grow_pend  <= 1'b0;
          idx        <= LEN_W'(1);
        end
        SCAN: begin
          if (bx[head_ptr - idx] == head_x && by[head_ptr - idx] == head_y)
            collide <= 1'b1;
          idx <= idx + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Randomised scoreboard bench for snake_body_tracker against a queue-based body model.
module tb_snake_body_tracker;
  localparam int CW = 5, LW = 5, MAXL = 31, INITL = 3, SX = 16, SY = 16;

  logic          clk = 1'b0, rst_n = 1'b0, step = 1'b0, grow = 1'b0;
  logic [1:0]    dir = 2'b01;
  logic [LW-1:0] seg_idx = '0;
  logic [CW-1:0] head_x, head_y, seg_x, seg_y;
  logic [LW-1:0] length;
  logic          busy, done, collide, seg_valid;

  snake_body_tracker #(
    .COORD_W(CW), .LEN_W(LW), .MAX_LEN(MAXL), .INIT_LEN(INITL),
    .START_X(SX), .START_Y(SY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .dir(dir), .grow(grow),
    .seg_idx(seg_idx), .head_x(head_x), .head_y(head_y), .length(length),
    .busy(busy), .done(done), .collide(collide), .seg_x(seg_x),
    .seg_y(seg_y), .seg_valid(seg_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: body as a queue, head at index 0
  typedef struct packed { logic [4:0] x; logic [4:0] y; } pt_t;
  pt_t        body[$];
  logic [1:0] m_dir;
  bit         m_col, m_pend;

  typedef struct { int done_cyc; int x; int y; int len; int col; } exp_t;
  typedef struct { int cyc; int valid; int x; int y; } rd_t;
  exp_t exp_q[$];
  rd_t  rd_q[$];

  function automatic void model_reset();
    body.delete();
    for (int i = 0; i < INITL; i++) body.push_back('{x: 5'(SX - i), y: 5'(SY)});
    m_dir  = 2'b01;
    m_col  = 1'b0;
    m_pend = 1'b0;
  endfunction

  function automatic void model_move(input logic [1:0] d, input bit g);
    pt_t nh;
    int  n;
    if (d != (m_dir ^ 2'b10)) m_dir = d;
    nh = body[0];
    case (m_dir)
      2'b00:   nh.y = nh.y - 5'd1;
      2'b01:   nh.x = nh.x + 5'd1;
      2'b10:   nh.y = nh.y + 5'd1;
      default: nh.x = nh.x - 5'd1;
    endcase
    n = body.size();
    body.push_front(nh);
    if (!(g && n < MAXL)) void'(body.pop_back());
    for (int k = 1; k < body.size(); k++) if (body[k] == nh) m_col = 1'b1;
  endfunction

  // ---------------- monitor: pops expectations when DUT presents results
  int   busy_run = 0;
  exp_t e;
  rd_t  r;
  initial forever begin
    @(posedge clk);
    #1;
    if (busy === 1'b1) busy_run++;
    else busy_run = 0;
    if (done === 1'b1) begin
      chk("done_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("head_x", 32'(head_x), e.x);
        chk("head_y", 32'(head_y), e.y);
        chk("length", 32'(length), e.len);
        chk("collide", 32'(collide), e.col);
        chk("busy_cycles", busy_run, e.len + 1);
      end
    end
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc - 1) begin
      r = rd_q.pop_front();
      chk("seg_valid", 32'(seg_valid), r.valid);
      if (r.valid != 0) begin
        chk("seg_x", 32'(seg_x), r.x);
        chk("seg_y", 32'(seg_y), r.y);
      end
    end
  end

  // ---------------- stimulus
  task automatic do_reset();
    rst_n = 1'b0;
    step  = 1'b0;
    grow  = 1'b0;
    exp_q.delete();
    rd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("rst_head_x", 32'(head_x), SX);
    chk("rst_head_y", 32'(head_y), SY);
    chk("rst_length", 32'(length), INITL);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_collide", 32'(collide), 0);
    chk("rst_seg_valid", 32'(seg_valid), 0);
    chk("rst_seg_x", 32'(seg_x), 0);
    chk("rst_seg_y", 32'(seg_y), 0);
  endtask

  task automatic rd(input int k);
    rd_t t;
    seg_idx = LW'(k);
    t.cyc   = cyc;
    t.valid = (k < body.size()) ? 1 : 0;
    t.x     = (k < body.size()) ? int'(body[k].x) : 0;
    t.y     = (k < body.size()) ? int'(body[k].y) : 0;
    rd_q.push_back(t);
    @(negedge clk);
  endtask

  task automatic idle_grow();
    grow   = 1'b1;
    m_pend = 1'b1;
    @(negedge clk);
    grow = 1'b0;
  endtask

  // gat: cycle of an accompanying grow pulse (0 step, 1 MOVE, 2 scan, else none)
  task automatic do_step(input logic [1:0] d, input int gat, input bit extra);
    int n, cnt;
    bit was_col;
    was_col = m_col;
    if (!was_col) begin
      model_move(d, m_pend || gat == 0 || gat == 1);
      m_pend = (gat == 2);
      exp_q.push_back('{done_cyc: cyc + body.size() + 1, x: int'(body[0].x),
                        y: int'(body[0].y), len: body.size(), col: int'(m_col)});
    end else if (gat >= 0 && gat <= 2) begin
      m_pend = 1'b1;
    end
    step = 1'b1; dir = d; grow = (gat == 0);
    @(negedge clk);
    step = 1'b0; grow = (gat == 1);
    @(negedge clk);
    step = extra; grow = (gat == 2);
    @(negedge clk);
    step = 1'b0; grow = 1'b0;
    if (was_col) begin
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        if (busy === 1'b1) cnt++;
        @(negedge clk);
      end
      chk("busy_after_collide", cnt, 0);
    end else begin
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("idle_timeout", n < 100, 1);
      chk("done_pending", exp_q.size(), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] d;
    int         g;
    model_reset();
    @(negedge clk);
    do_reset();
    rd(0); rd(1); rd(2); rd(3); rd(31);

    do_step(2'b01, -1, 1'b0);        // plain move right
    do_step(2'b11, -1, 1'b1);        // reverse ignored; extra step while busy
    idle_grow();
    do_step(2'b01, -1, 1'b0);        // grows to 4
    rd(0); rd(3); rd(4);

    while (body[0].x != 5'd31) do_step(2'b01, -1, 1'b0);
    do_step(2'b01, -1, 1'b0);        // 31 -> 0
    while (body[0].x != 5'd5) do_step(2'b01, -1, 1'b0);
    while (body[0].y != 5'd0) do_step(2'b00, -1, 1'b0);
    do_step(2'b00, -1, 1'b0);        // 0 -> 31
    do_step(2'b10, -1, 1'b0);        // reverse of up ignored

    do_reset();
    do_step(2'b01, 0, 1'b0);
    do_step(2'b01, 1, 1'b0);         // length 5
    do_step(2'b00, -1, 1'b0);
    do_step(2'b11, -1, 1'b0);
    do_step(2'b10, -1, 1'b0);        // bites the body
    chk("collide_model", 32'(m_col), 1);
    chk("collide_sticky", 32'(collide), 1);
    do_step(2'b01, -1, 1'b0);        // ignored

    do_reset();
    step = 1'b1; dir = 2'b01;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_midscan", 32'(busy), 1);
    do_reset();                      // abort during scan

    do_reset();
    for (int i = 0; i < 30; i++) do_step(2'b01, 0, 1'b0);
    chk("sat_length", 32'(length), MAXL);
    do_step(2'b01, 1, 1'b0);
    rd(30); rd(31);

    do_reset();
    for (int i = 0; i < 150; i++) begin
      if (m_col && $urandom_range(0, 1) == 0) do_reset();
      if ($urandom_range(0, 5) == 0) idle_grow();
      d = 2'($urandom_range(0, 3));
      g = $urandom_range(0, 5) - 1;
      do_step(d, g, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        rd($urandom_range(0, 31));
        rd($urandom_range(0, body.size()));
      end
    end

    repeat (3) @(negedge clk);
    chk("exp_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/snake_body_tracker.md
Name: snake_body_tracker

Overview:
- Stores the snake body as a circular buffer of grid coordinates. Advances the head one cell per move step.
- Grows the body on request, up to a fixed maximum. After each move, checks head-to-body collision with a sequential scan.
- Sits downstream of the game-tick/length counter stage: consumes its step pulse and grow requests. Feeds the renderer through a segment read port and the game-control FSM through done/collide.

Parameters:
- COORD_W, 5, bits per X/Y coordinate; grid is 2^COORD_W cells square.
- LEN_W, 5, length/pointer width; buffer depth is 2^LEN_W entries.
- MAX_LEN, 31, maximum body length; must be <= 2^LEN_W - 1.
- INIT_LEN, 3, length after reset; range 1..MAX_LEN.
- START_X, 16, head X after reset.
- START_Y, 16, head Y after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- step  input  1  one-cycle move request.
- dir  input  2  requested heading: 00 up (Y-1), 01 right (X+1), 10 down (Y+1), 11 left (X-1).
- grow  input  1  one-cycle grow request.
- seg_idx  input  LEN_W  renderer segment index; 0 = head.
- head_x  output  COORD_W  current head X.
- head_y  output  COORD_W  current head Y.
- length  output  LEN_W  current body length.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse when a move plus scan completes.
- collide  output  1  sticky self-collision flag.
- seg_x  output  COORD_W  X of segment seg_idx, registered.
- seg_y  output  COORD_W  Y of segment seg_idx, registered.
- seg_valid  output  1  registered (seg_idx < length).

Behaviour:
- Interface: single clock clk. Reset rst_n is synchronous and active-low. Asserting rst_n low mid-operation aborts any move/scan and restores reset values on the next edge.
- Reset values:
  - state IDLE; head pointer 0; length = INIT_LEN; heading = right.
  - segment i (i = 0..INIT_LEN-1) = (START_X - i, START_Y); all other buffer entries 0.
  - busy = 0, done = 0, collide = 0, grow_pend = 0.
  - seg_x = 0, seg_y = 0, seg_valid = 0.
- Addressing: segment i is buffer entry (head_ptr - i) mod 2^LEN_W.
- States and transitions:
  - IDLE: step sampled high with collide = 0 -> MOVE. Step is ignored while busy or while collide = 1.
  - MOVE (1 cycle):
    - Update heading: dir is accepted unless it is the exact reverse of the current heading; a reverse request is ignored.
    - New head = old head + 1 cell in the heading direction, modulo 2^COORD_W. 0 - 1 -> 31 and 31 + 1 -> 0 (COORD_W = 5).
    - head_ptr += 1 (mod 2^LEN_W); write the new head there.
    - If grow_pend = 1 and length < MAX_LEN: length += 1. grow_pend is cleared regardless.
    - Next state: length_new = 1 -> DONE, otherwise -> SCAN with idx = 1.
  - SCAN: one compare per cycle of the head against segment idx, idx = 1..length_new-1.
    - A match sets collide (sticky until reset). The scan still completes.
    - After idx = length_new-1 -> DONE.
  - DONE (1 cycle): done = 1 -> IDLE.
- Latency: with the step-sampled cycle as cycle 0, done is high in cycle length_new + 1. busy is high in cycles 1..length_new + 1.
- Grow:
  - A grow pulse in any cycle sets grow_pend.
  - A grow in the same cycle as the MOVE state is applied to that move.
  - Multiple grows before a move collapse to +1.
  - At MAX_LEN, length saturates and the request is dropped.
- Tail: the vacated old-tail cell is not part of the body after MOVE and is never compared.
- Read port:
  - seg_x/seg_y/seg_valid are registered, 1-cycle latency from seg_idx.
  - When seg_idx >= length, seg_valid = 0 and the coordinate values are don't-care.
  - The read port is valid in every state. During MOVE it reflects pre-update contents.

Test Plan:
- Reset, INIT_LEN=3, START=(16,16) -> head (16,16), length 3; seg_idx 1,2 read back (15,16),(14,16) with seg_valid=1; seg_idx 3 -> seg_valid=0.
- step with dir=01 -> head (17,16); done high exactly 4 cycles after the step cycle; busy high cycles 1-4; collide=0.
- Head at (31,16) heading right, step -> head (0,16). Head at (5,0), dir=00, step -> head (5,31).
- Heading right, step with dir=11 -> reversal ignored, head X+1. Second step issued while busy -> ignored, only one done pulse.
- grow pulse, then step -> length 4, tail retained. 30 grow+step pairs from length 3 -> length saturates at 31, no wrap.
- Length 5, steps up, left, down -> collide=1 sticky; a later step produces no busy/done. rst_n low during SCAN -> reset values on the next edge.
